// File: rtl/lin_vote.sv
// Frame brightness voter: counts bright pixels per frame, freezes the count
// at the end of the last active line, and debounces the resulting bright/dark vote.
module lin_vote #(
   parameter int CH       = 3,
   parameter int MAX      = 2,
   parameter int LUM_TH   = 128,
   parameter int HI_TH    = MAX / 2,
   parameter int LO_TH    = MAX / 2,
   parameter int DEBOUNCE = 1,
   localparam int W       = $clog2(MAX + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            vp_last_i,
   input  logic            de_i,
   input  logic [8*CH-1:0] wd_i,
   output logic            rx_o,
   output logic [W-1:0]    count_o,
   output logic            valid_o
);

   if (CH < 1 || CH > 4) begin : g_bad_ch
      $error("lin_vote: CH must be 1..4");
   end
   if (MAX < 1 || HI_TH > MAX || LO_TH > HI_TH || LO_TH < 0) begin : g_bad_th
      $error("lin_vote: thresholds must satisfy 0 <= LO_TH <= HI_TH <= MAX, MAX >= 1");
   end
   if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_db
      $error("lin_vote: DEBOUNCE must be 1..15");
   end

   localparam logic [9:0]   SUM_TH  = 10'(CH * LUM_TH);
   localparam logic [W-1:0] CNT_MAX = W'(MAX);
   localparam logic [W-1:0] HI_V    = W'(HI_TH);
   localparam logic [W-1:0] LO_V    = W'(LO_TH);
   localparam logic [3:0]   DB_V    = 4'(DEBOUNCE);

   typedef enum logic [1:0] {
      V_HOLD,
      V_BRIGHT,
      V_DARK
   } vote_t;

   logic [9:0]   sum;
   logic         bright;
   logic         de_r;
   logic         freeze;
   logic         upd;
   logic [W-1:0] cnt_run;
   logic [W-1:0] frozen;
   logic [3:0]   dbc;
   logic [3:0]   dbc_next;
   logic [3:0]   dbc_inc;
   logic         rx_next;
   logic         opp;
   vote_t        vote;

   // channel sum is 10 bits so 4 x 255 never truncates
   always_comb begin
      sum = '0;
      for (int k = 0; k < CH; k++) begin
         sum = sum + 10'(wd_i[8*k +: 8]);
      end
   end

   assign bright = de_i && (sum >= SUM_TH);
   // falling edge of de during the last line marks the end of the frame
   assign freeze = vp_last_i && !de_i && de_r;

   always_comb begin
      vote = V_HOLD;
      if (frozen >= HI_V) begin
         vote = V_BRIGHT;
      end else if (frozen < LO_V) begin
         vote = V_DARK;
      end
   end

   always_comb begin
      opp      = ((vote == V_BRIGHT) && !rx_o) || ((vote == V_DARK) && rx_o);
      dbc_inc  = dbc + 4'd1;
      rx_next  = rx_o;
      dbc_next = '0;
      if (opp) begin
         if (dbc_inc == DB_V) begin
            rx_next = !rx_o;
         end else begin
            dbc_next = dbc_inc;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         de_r    <= 1'b0;
         cnt_run <= '0;
         frozen  <= '0;
         upd     <= 1'b0;
         dbc     <= '0;
         rx_o    <= 1'b0;
         count_o <= '0;
         valid_o <= 1'b0;
      end else begin
         de_r    <= de_i;
         valid_o <= upd;
         if (freeze) begin
            frozen  <= cnt_run;
            cnt_run <= '0;
            upd     <= 1'b1;
         end else begin
            upd <= 1'b0;
            if (bright && (cnt_run != CNT_MAX)) begin
               cnt_run <= cnt_run + 1'b1;
            end
         end
         if (upd) begin
            count_o <= frozen;
            rx_o    <= rx_next;
            dbc     <= dbc_next;
         end
      end
   end

endmodule

// File: tb/tb_lin_vote.sv
// Scoreboard bench for lin_vote: each freeze pushes the expected count/decision,
// a negedge monitor pops and compares on every valid_o pulse.
module tb_lin_vote;

   localparam int CH = 3, MAX = 16, LUM_TH = 128, HI_TH = 10, LO_TH = 6, DEBOUNCE = 2;
   localparam int W = $clog2(MAX + 1);

   typedef struct {
      int cnt;
      bit rx;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            vp_last = 1'b0;
   logic            de = 1'b0;
   logic [8*CH-1:0] wd = '0;
   logic            rx;
   logic [W-1:0]    count;
   logic            valid;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   int   m_run = 0;
   bit   m_rx = 1'b0;
   int   m_dbc = 0;

   lin_vote #(
      .CH(CH), .MAX(MAX), .LUM_TH(LUM_TH), .HI_TH(HI_TH), .LO_TH(LO_TH), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .vp_last_i(vp_last), .de_i(de), .wd_i(wd),
      .rx_o(rx), .count_o(count), .valid_o(valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: valid_o high with nothing expected, count_o=%0d", count);
         end else begin
            e = q.pop_front();
            if (count !== W'(e.cnt)) begin
               errors++;
               $display("FAIL count_o: got %0d expected %0d", count, e.cnt);
            end
            checks++;
            if (rx !== e.rx) begin
               errors++;
               $display("FAIL rx_o: got %0b expected %0b (count %0d)", rx, e.rx, e.cnt);
            end
         end
      end
   end

   function automatic bit is_bright(input logic [23:0] p);
      int s;
      s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]);
      return s >= CH * LUM_TH;
   endfunction

   task automatic pixel(input logic [23:0] p, input logic vp);
      vp_last = vp;
      de      = 1'b1;
      wd      = p;
      if (is_bright(p)) m_run++;
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic vp);
      vp_last = vp;
      de      = 1'b0;
      wd      = '0;
      @(posedge clk); #1;
   endtask

   // drives the freeze cycle and pushes the expected outcome
   task automatic freeze_cycle(input bit chk_lat);
      exp_t e;
      bit   opp;
      e.cnt = (m_run > MAX) ? MAX : m_run;
      m_run = 0;
      opp = ((e.cnt >= HI_TH) && !m_rx) || ((e.cnt < LO_TH) && m_rx);
      if (opp) begin
         m_dbc++;
         if (m_dbc == DEBOUNCE) begin
            m_rx  = !m_rx;
            m_dbc = 0;
         end
      end else begin
         m_dbc = 0;
      end
      e.rx = m_rx;
      q.push_back(e);
      vp_last = 1'b1;
      de      = 1'b0;
      wd      = '0;
      @(posedge clk); #1;
      vp_last = 1'b0;
      if (chk_lat) begin
         checks++;
         if (valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid_o=%b one edge after freeze, expected 0", valid);
         end
         @(posedge clk); #1;
         checks++;
         if (valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: valid_o=%b two edges after freeze, expected 1", valid);
         end
      end
   endtask

   task automatic frame(input int nb, input int nd, input logic [23:0] bv, input logic [23:0] dv);
      int n;
      n = nb + nd;
      for (int i = 0; i < n; i++) begin
         if (i == n / 2 && i > 0) idle(1'b0);
         pixel((i < nb) ? bv : dv, (i >= n / 2));
      end
      freeze_cycle(1'b1);
   endtask

   task automatic drain;
      for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected valid_o pulses missing, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset;
      rst     = 1'b1;
      de      = 1'b1;
      wd      = 24'hFFFFFF;
      vp_last = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (rx !== 1'b0 || valid !== 1'b0 || count !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rx=%b valid=%b count=%0d expected 0/0/0", rx, valid, count);
      end
      q.delete();
      m_run = 0;
      m_rx  = 1'b0;
      m_dbc = 0;
      rst   = 1'b0;
      de    = 1'b0;
      wd    = '0;
      // de_r must be clear, so this cycle is not a freeze
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
   endtask

   task automatic test_reset;
      do_reset();
   endtask

   task automatic test_bright_debounce;
      frame(12, 0, 24'hFFFFFF, 24'h000000);
      frame(12, 0, 24'hFFFFFF, 24'h000000);
      drain();
   endtask

   task automatic test_saturate;
      frame(40, 0, 24'hFFFFFF, 24'h000000);
      drain();
   endtask

   task automatic test_hold_debounce;
      frame(3, 5, 24'hFFFFFF, 24'h000000);
      frame(8, 0, 24'hFFFFFF, 24'h000000);
      frame(3, 0, 24'hFFFFFF, 24'h000000);
      frame(3, 0, 24'hFFFFFF, 24'h000000);
      drain();
      checks++;
      if (rx !== 1'b0) begin
         errors++;
         $display("FAIL hold_debounce_final: rx_o=%b expected 0", rx);
      end
   endtask

   task automatic test_threshold;
      frame(1, 3, 24'h808080, 24'h80807F);
      frame(2, 2, 24'h7F8080, 24'h80807F);
      drain();
   endtask

   task automatic test_vote_bounds;
      frame(10, 0, 24'hFFFFFF, 24'h000000);
      frame(10, 0, 24'hFFFFFF, 24'h000000);
      frame(6, 0, 24'hFFFFFF, 24'h000000);
      frame(5, 0, 24'hFFFFFF, 24'h000000);
      frame(6, 0, 24'hFFFFFF, 24'h000000);
      frame(5, 0, 24'hFFFFFF, 24'h000000);
      frame(5, 0, 24'hFFFFFF, 24'h000000);
      drain();
   endtask

   task automatic test_no_freeze;
      for (int i = 0; i < 5; i++) begin
         pixel(24'hFFFFFF, 1'b0);
         idle(1'b0);
      end
      frame(3, 0, 24'hFFFFFF, 24'h000000);
      drain();
   endtask

   task automatic test_back_to_back;
      pixel(24'hFFFFFF, 1'b1);
      freeze_cycle(1'b0);
      pixel(24'h000000, 1'b1);
      freeze_cycle(1'b0);
      idle(1'b0);
      drain();
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 9; i++) pixel(24'hFFFFFF, 1'b0);
      do_reset();
      frame(4, 0, 24'hFFFFFF, 24'h000000);
      drain();
   endtask

   initial begin
      idle(1'b0);
      test_reset();
      test_bright_debounce();
      test_saturate();
      test_hold_debounce();
      test_threshold();
      test_vote_bounds();
      test_no_freeze();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
